// File: rtl/shift_exec_pkg.sv
// Shared constants and funct decoding for the EX-stage shift unit.
// The decode function is the single source of truth for funct -> {err, var_sel, ctr}.
package shift_exec_pkg;

  localparam int FUNCT_W = 6;
  localparam int DATA_W  = 32;
  localparam int AMT_W   = 5;
  localparam int TAG_W   = 5;

  localparam logic [FUNCT_W-1:0] FUNCT_SLL  = 6'b000000;
  localparam logic [FUNCT_W-1:0] FUNCT_SRL  = 6'b000010;
  localparam logic [FUNCT_W-1:0] FUNCT_SRA  = 6'b000011;
  localparam logic [FUNCT_W-1:0] FUNCT_SLLV = 6'b000100;
  localparam logic [FUNCT_W-1:0] FUNCT_SRLV = 6'b000110;
  localparam logic [FUNCT_W-1:0] FUNCT_SRAV = 6'b000111;

  localparam logic [1:0] CTR_NONE = 2'b00;
  localparam logic [1:0] CTR_SLL  = 2'b01;
  localparam logic [1:0] CTR_SRA  = 2'b10;
  localparam logic [1:0] CTR_SRL  = 2'b11;

  typedef struct packed {
    logic       err;
    logic       var_sel;  // 1: amount from rs[4:0], 0: from shamt
    logic [1:0] ctr;
  } dec_t;

  function automatic dec_t decode_funct(input logic [FUNCT_W-1:0] funct);
    dec_t r;
    r = '{err: 1'b1, var_sel: 1'b0, ctr: CTR_NONE};
    case (funct)
      FUNCT_SLL:  r = '{err: 1'b0, var_sel: 1'b0, ctr: CTR_SLL};
      FUNCT_SRL:  r = '{err: 1'b0, var_sel: 1'b0, ctr: CTR_SRL};
      FUNCT_SRA:  r = '{err: 1'b0, var_sel: 1'b0, ctr: CTR_SRA};
      FUNCT_SLLV: r = '{err: 1'b0, var_sel: 1'b1, ctr: CTR_SLL};
      FUNCT_SRLV: r = '{err: 1'b0, var_sel: 1'b1, ctr: CTR_SRL};
      FUNCT_SRAV: r = '{err: 1'b0, var_sel: 1'b1, ctr: CTR_SRA};
      default:    r = '{err: 1'b1, var_sel: 1'b0, ctr: CTR_NONE};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/barrelshifter32.sv
// 32-bit barrel shifter: ctr 01=sll, 11=srl, 10=sra (fills with a[31]), 00=pass-through.
// Purely combinational.
module barrelshifter32 (
  input  logic [31:0] a,
  input  logic [4:0]  b,
  input  logic [1:0]  ctr,
  output logic [31:0] d
);

  always_comb begin
    case (ctr)
      2'b01:   d = a << b;
      2'b11:   d = a >> b;
      2'b10:   d = $signed(a) >>> b;
      default: d = a;
    endcase
  end

endmodule

// File: rtl/shift_decode.sv
// Combinational funct decoder: shift control, amount-source select and illegal-op flag.
// Zero latency; no flow control.
module shift_decode
  import shift_exec_pkg::*;
(
  input  logic [FUNCT_W-1:0] funct_i,
  output logic [1:0]         ctr_o,
  output logic               var_sel_o,
  output logic               err_o
);

  dec_t dec;

  always_comb begin
    dec       = decode_funct(funct_i);
    ctr_o     = dec.ctr;
    var_sel_o = dec.var_sel;
    err_o     = dec.err;
  end

endmodule

// File: rtl/shift_exec_unit.sv
// Two-stage shift execution unit: S1 holds decoded operands feeding the shifter, S2 holds the result.
// Latency 2 cycles, 1 op/cycle; stalls via in_ready when S2 is held by out_ready=0; flush squashes both stages.
module shift_exec_unit
  import shift_exec_pkg::*;
#(
  parameter int FUNCT_W = shift_exec_pkg::FUNCT_W,
  parameter int DATA_W  = shift_exec_pkg::DATA_W   // barrelshifter32 fixes this at 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FUNCT_W-1:0] in_funct,
  input  logic [DATA_W-1:0]  in_rt,
  input  logic [DATA_W-1:0]  in_rs,
  input  logic [AMT_W-1:0]   in_shamt,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_result,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_err
);

  logic [1:0]       dec_ctr;
  logic             dec_var_sel;
  logic             dec_err;
  logic [AMT_W-1:0] dec_amt;

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_rt_q, s1_rt_d;
  logic [AMT_W-1:0]  s1_amt_q, s1_amt_d;
  logic [1:0]        s1_ctr_q, s1_ctr_d;
  logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
  logic              s1_err_q, s1_err_d;

  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s2_res_q, s2_res_d;
  logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;
  logic              s2_err_q, s2_err_d;

  logic [DATA_W-1:0] bs_d;
  logic              s2_free, s1_adv, accept;

  shift_decode u_decode (
    .funct_i   (in_funct),
    .ctr_o     (dec_ctr),
    .var_sel_o (dec_var_sel),
    .err_o     (dec_err)
  );

  barrelshifter32 u_shifter (
    .a   (s1_rt_q),
    .b   (s1_amt_q),
    .ctr (s1_ctr_q),
    .d   (bs_d)
  );

  // Only rs[4:0] matters for variable shifts; illegal ops carry amount 0.
  assign dec_amt = dec_err ? '0 : (dec_var_sel ? in_rs[AMT_W-1:0] : in_shamt);

  assign s2_free  = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  assign in_ready = !s1_valid_q || s2_free;
  assign accept   = in_valid && in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_rt_d    = s1_rt_q;
    s1_amt_d   = s1_amt_q;
    s1_ctr_d   = s1_ctr_q;
    s1_tag_d   = s1_tag_q;
    s1_err_d   = s1_err_q;
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_tag_d   = s2_tag_q;
    s2_err_d   = s2_err_q;

    // Flush wins over every advance; an op offered this cycle is dropped.
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
      s2_err_d   = 1'b0;
    end else begin
      if (s1_adv) begin
        s2_valid_d = 1'b1;
        s2_res_d   = s1_err_q ? '0 : bs_d;
        s2_tag_d   = s1_tag_q;
        s2_err_d   = s1_err_q;
      end else if (out_ready) begin
        s2_valid_d = 1'b0;
      end

      if (accept) begin
        s1_valid_d = 1'b1;
        s1_rt_d    = in_rt;
        s1_amt_d   = dec_amt;
        s1_ctr_d   = dec_ctr;
        s1_tag_d   = in_tag;
        s1_err_d   = dec_err;
      end else if (s1_adv) begin
        s1_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_rt_q    <= '0;
      s1_amt_q   <= '0;
      s1_ctr_q   <= CTR_NONE;
      s1_tag_q   <= '0;
      s1_err_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_tag_q   <= '0;
      s2_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_rt_q    <= s1_rt_d;
      s1_amt_q   <= s1_amt_d;
      s1_ctr_q   <= s1_ctr_d;
      s1_tag_q   <= s1_tag_d;
      s1_err_q   <= s1_err_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_tag_q   <= s2_tag_d;
      s2_err_q   <= s2_err_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_res_q;
  assign out_tag    = s2_tag_q;
  assign out_err    = s2_err_q;

endmodule

// File: tb/tb_shift_exec_unit.sv
// Scoreboard bench for shift_exec_unit: directed cases from the shift rules, then randomized traffic.
module tb_shift_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_funct;
  logic [31:0] in_rt;
  logic [31:0] in_rs;
  logic [4:0]  in_shamt;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        out_err;

  shift_exec_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_funct   (in_funct),
    .in_rt      (in_rt),
    .in_rs      (in_rs),
    .in_shamt   (in_shamt),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    logic        err;
    int          acc_cyc;
    bit          strict;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   strict_lat = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: MIPS shift semantics in plain arithmetic. Returns {err, result}.
  function automatic logic [32:0] ref_shift(input logic [5:0] f, input logic [31:0] rt,
                                            input logic [31:0] rs, input logic [4:0] sh);
    int unsigned amt;
    logic [63:0] ext;
    logic [63:0] prod;
    amt = (f == 6'd4 || f == 6'd6 || f == 6'd7) ? int'(rs % 32) : int'(sh);
    case (f)
      6'd0, 6'd4: begin
        prod = {32'd0, rt} * (64'd1 << amt);
        return {1'b0, prod[31:0]};
      end
      6'd2, 6'd6: return {1'b0, rt / (32'd1 << amt)};
      6'd3, 6'd7: begin
        ext = {(rt[31] ? 32'hFFFF_FFFF : 32'd0), rt};
        ext = ext / (64'd1 << amt);
        return {1'b0, ext[31:0]};
      end
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples mid-cycle, while inputs and DUT state are stable.
  bit          stalled = 1'b0;
  logic [31:0] snap_res;
  logic [4:0]  snap_tag;
  logic        snap_err;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      stalled = 1'b0;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_result", out_result, 32'd0);
      chk("rst_out_err", {31'd0, out_err}, 32'd0);
    end else begin
      if (stalled) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_result", out_result, snap_res);
        chk("hold_tag", {27'd0, out_tag}, {27'd0, snap_tag});
        chk("hold_err", {31'd0, out_err}, {31'd0, snap_err});
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result", out_result, e.res);
          chk("tag", {27'd0, out_tag}, {27'd0, e.tag});
          chk("err", {31'd0, out_err}, {31'd0, e.err});
          if (e.strict) chk("latency", cyc - e.acc_cyc, 32'd2);
        end
      end
      if (out_valid && !out_ready && !flush) begin
        stalled  = 1'b1;
        snap_res = out_result;
        snap_tag = out_tag;
        snap_err = out_err;
      end else begin
        stalled = 1'b0;
      end
      if (flush) begin
        q.delete();
      end else if (in_valid && in_ready) begin
        exp_t e;
        logic [32:0] r;
        r = ref_shift(in_funct, in_rt, in_rs, in_shamt);
        e.res = r[31:0];
        e.err = r[32];
        e.tag = in_tag;
        e.acc_cyc = cyc;
        e.strict = strict_lat;
        q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one op and returns in the cycle after it is accepted (bounded wait).
  task automatic issue(input logic [5:0] f, input logic [31:0] rt, input logic [31:0] rs,
                       input logic [4:0] sh, input logic [4:0] tag);
    bit ok;
    in_funct = f; in_rt = rt; in_rs = rs; in_shamt = sh; in_tag = tag;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [5:0] legal [6];
    legal[0] = 6'd0; legal[1] = 6'd2; legal[2] = 6'd3;
    legal[3] = 6'd4; legal[4] = 6'd6; legal[5] = 6'd7;

    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_funct = '0; in_rt = '0; in_rs = '0; in_shamt = '0; in_tag = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_tag", {27'd0, out_tag}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
    idle(1);

    strict_lat = 1'b1;
    issue(6'd0, 32'h1222_0023, 32'd0, 5'd4, 5'd1);
    chk("ref_sll", ref_shift(6'd0, 32'h1222_0023, 32'd0, 5'd4), {1'b0, 32'h2220_0230});
    idle(3);
    issue(6'd2, 32'hF222_0023, 32'd0, 5'd4, 5'd2);
    issue(6'd3, 32'hF222_0023, 32'd0, 5'd4, 5'd3);
    idle(3);
    issue(6'd7, 32'h8000_0000, 32'hFFFF_FFE4, 5'd0, 5'd4);
    issue(6'd4, 32'hDEAD_BEEF, 32'd0, 5'd9, 5'd5);
    idle(3);
    issue(6'h20, 32'h1234_5678, 32'd0, 5'd3, 5'd6);
    issue(6'd0, 32'h0000_0001, 32'd0, 5'd31, 5'd7);
    idle(4);

    // Back-pressure: fill both stages, third op must wait.
    strict_lat = 1'b0;
    out_ready = 1'b0;
    issue(6'd2, 32'hAAAA_5555, 32'd0, 5'd1, 5'd8);
    issue(6'd3, 32'h8000_0001, 32'd0, 5'd31, 5'd9);
    in_funct = 6'd6; in_rt = 32'hFFFF_0000; in_rs = 32'h0000_0108; in_tag = 5'd10;
    in_valid = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    tick();
    @(negedge clk);
    chk("bp_in_ready_still_low", {31'd0, in_ready}, 32'd0);
    tick();
    out_ready = 1'b1;
    issue(6'd6, 32'hFFFF_0000, 32'h0000_0108, 5'd0, 5'd10);
    idle(5);

    // Flush with both stages full; the op offered during flush is dropped.
    out_ready = 1'b0;
    issue(6'd0, 32'h0000_00FF, 32'd0, 5'd8, 5'd11);
    issue(6'd2, 32'h0000_FF00, 32'd0, 5'd8, 5'd12);
    flush = 1'b1;
    in_funct = 6'd0; in_rt = 32'h1; in_shamt = 5'd1; in_tag = 5'd13; in_valid = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_out_err", {31'd0, out_err}, 32'd0);
    out_ready = 1'b1;
    idle(4);

    // Async reset mid-stream: in-flight ops vanish.
    in_funct = 6'd0; in_rt = 32'h5; in_shamt = 5'd2; in_tag = 5'd14; in_valid = 1'b1;
    tick();
    in_tag = 5'd15;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_result", out_result, 32'd0);
    tick();
    rst_n = 1'b1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    strict_lat = 1'b1;
    issue(6'd3, 32'h4000_0000, 32'd0, 5'd30, 5'd16);
    idle(4);

    // Randomized traffic with back-pressure and occasional flush.
    strict_lat = 1'b0;
    repeat (600) begin
      if ($urandom_range(0, 9) < 8) in_funct = legal[$urandom_range(0, 5)];
      else in_funct = 6'($urandom);
      in_rt     = $urandom;
      in_rs     = $urandom;
      in_shamt  = 5'($urandom);
      in_tag    = 5'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    idle(6);
    chk("drain_empty", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
